// File: rtl/instr_issue_controller.sv
// Instruction issue queue: buffers fetched (pc, instr) pairs in a small circular FIFO and offers
// the head to decode, serialising SYSTEM/FENCE instructions behind an idle execute stage.
module instr_issue_controller #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_valid,
    output logic                     f_ready,
    input  logic [31:0]              f_instr,
    input  logic [31:0]              f_pc,
    output logic                     d_valid,
    input  logic                     d_ready,
    output logic [31:0]              d_instr,
    output logic [31:0]              d_pc,
    output logic [2:0]               d_class,
    output logic                     d_illegal,
    input  logic                     ex_busy,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef logic [PtrW:0]   occ_t;
    typedef logic [PtrW-1:0] ptr_t;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHold
    } state_e;

    localparam occ_t OccFull = occ_t'(DEPTH);

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    occ_t   occ_q, occ_d;
    state_e state_q, state_d;

    logic        push, pop, empty;
    logic [31:0] head_instr, head_pc;
    logic [2:0]  head_class;
    logic        head_illegal;
    logic        head_serial;

    assign empty      = (occ_q == '0);
    assign head_instr = instr_mem[rd_ptr_q];
    assign head_pc    = pc_mem[rd_ptr_q];

    assign f_ready   = (occ_q < OccFull) && !flush;
    assign push      = f_valid && f_ready;
    assign pop       = d_valid && d_ready;
    assign occupancy = occ_q;

    always_comb begin
        head_class   = 3'd0;
        head_illegal = 1'b0;
        case (head_instr[6:0])
            7'b0110011:             head_class = 3'd0;
            7'b0010011:             head_class = 3'd1;
            7'b0000011:             head_class = 3'd2;
            7'b0100011:             head_class = 3'd3;
            7'b1100011:             head_class = 3'd4;
            7'b1101111, 7'b1100111: head_class = 3'd5;
            7'b0110111, 7'b0010111: head_class = 3'd6;
            7'b1110011, 7'b0001111: head_class = 3'd7;
            default:                head_illegal = 1'b1;
        endcase
    end

    assign head_serial = !empty && (head_class == 3'd7);

    // Head fields are masked to zero while the queue is empty so stale storage never leaks out.
    assign d_instr   = empty ? 32'd0 : head_instr;
    assign d_pc      = empty ? 32'd0 : head_pc;
    assign d_class   = empty ? 3'd0  : head_class;
    assign d_illegal = empty ? 1'b0  : head_illegal;

    always_comb begin
        d_valid = 1'b0;
        case (state_q)
            StRun:   d_valid = !empty && !head_serial;
            StDrain: d_valid = !empty && !ex_busy;
            default: d_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (head_serial) state_d = StDrain;
            StDrain: if (pop)         state_d = StHold;
            StHold:  if (!ex_busy)    state_d = StRun;
            default:                  state_d = StRun;
        endcase
        if (flush) begin
            state_d = StRun;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            // A handshake in the flush cycle still counts as issued; everything else is dropped.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            occ_d = occ_q + occ_t'(push) - occ_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            state_q  <= StRun;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= f_instr;
            pc_mem[wr_ptr_q]    <= f_pc;
        end
    end

endmodule

// File: tb/tb_instr_issue_controller.sv
// Directed bench for instr_issue_controller: stimulus pushes expected issues into a scoreboard
// queue, and a negedge monitor compares every decode handshake against it.
module tb_instr_issue_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [2:0]  d_class;
    logic        d_illegal;
    logic        ex_busy;
    logic        flush;
    logic [1:0]  occupancy;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  cls;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   issued = 0;

    always #5 clk = ~clk;

    instr_issue_controller #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .f_instr   (f_instr),
        .f_pc      (f_pc),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_instr   (d_instr),
        .d_pc      (d_pc),
        .d_class   (d_class),
        .d_illegal (d_illegal),
        .ex_busy   (ex_busy),
        .flush     (flush),
        .occupancy (occupancy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake outside reset must match the oldest expected issue.
    always @(negedge clk) begin
        if (rst === 1'b0 && d_valid === 1'b1 && d_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got pc 0x%0h expected no issue", d_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("issue_pc", d_pc, e.pc);
                chk("issue_instr", d_instr, e.instr);
                chk("issue_class", 32'(d_class), 32'(e.cls));
                chk("issue_illegal", 32'(d_illegal), 32'(e.ill));
                issued++;
            end
        end
    end

    task automatic push_one(input logic [31:0] pc, input logic [31:0] instr,
                            input logic [2:0] cls, input logic ill);
        int n = 0;
        exp_t e;
        f_valid = 1'b1;
        f_pc    = pc;
        f_instr = instr;
        @(negedge clk);
        while (f_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (f_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got f_ready=%b expected 1 for pc 0x%0h", f_ready, pc);
        end else begin
            e.pc = pc; e.instr = instr; e.cls = cls; e.ill = ill;
            exp_q.push_back(e);
        end
        cyc();
        f_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        @(negedge clk);
        while (occupancy !== 2'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_occupancy", 32'(occupancy), 32'd0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; f_valid = 1'b0; f_instr = '0; f_pc = '0;
        d_ready = 1'b0; ex_busy = 1'b0; flush = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_d_instr", d_instr, 32'd0);
        chk("rst_d_pc", d_pc, 32'd0);
        chk("rst_d_class", 32'(d_class), 32'd0);
        chk("rst_d_illegal", 32'(d_illegal), 32'd0);
        chk("rst_f_ready", 32'(f_ready), 32'd1);
        cyc();

        // Single addi: no bypass, visible one cycle after the push, then popped.
        d_ready = 1'b1;
        f_valid = 1'b1; f_pc = 32'h100; f_instr = 32'h0050_0093;
        @(negedge clk);
        chk("nobypass_d_valid", 32'(d_valid), 32'd0);
        chk("nobypass_f_ready", 32'(f_ready), 32'd1);
        exp_q.push_back('{pc: 32'h100, instr: 32'h0050_0093, cls: 3'd1, ill: 1'b0});
        cyc();
        f_valid = 1'b0;
        @(negedge clk);
        chk("addi_occupancy", 32'(occupancy), 32'd1);
        chk("addi_d_valid", 32'(d_valid), 32'd1);
        cyc();
        @(negedge clk);
        chk("addi_popped_occ", 32'(occupancy), 32'd0);
        chk("addi_popped_valid", 32'(d_valid), 32'd0);
        cyc();

        // Full queue back-pressures fetch; third instr waits for a pop.
        d_ready = 1'b0;
        push_one(32'h200, 32'h00a0_0113, 3'd1, 1'b0);
        push_one(32'h204, 32'h0020_81b3, 3'd0, 1'b0);
        f_valid = 1'b1; f_pc = 32'h208; f_instr = 32'h0001_2183;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_f_ready", 32'(f_ready), 32'd0);
            chk("full_occupancy", 32'(occupancy), 32'd2);
            chk("full_head", d_instr, 32'h00a0_0113);
            cyc();
        end
        d_ready = 1'b1;
        push_one(32'h208, 32'h0001_2183, 3'd2, 1'b0);
        wait_empty();

        // ecall waits for execute to go idle, then HOLD blocks the following addi.
        ex_busy = 1'b1;
        push_one(32'h300, 32'h0000_0073, 3'd7, 1'b0);
        push_one(32'h304, 32'h0010_0093, 3'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_busy_valid", 32'(d_valid), 32'd0);
            cyc();
        end
        ex_busy = 1'b0;
        @(negedge clk);
        chk("drain_idle_valid", 32'(d_valid), 32'd1);
        cyc();
        ex_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(d_valid), 32'd0);
            chk("hold_occupancy", 32'(occupancy), 32'd1);
            cyc();
        end
        ex_busy = 1'b0;
        @(negedge clk);
        chk("hold_exit_valid", 32'(d_valid), 32'd0);
        cyc();
        wait_empty();

        // Flush with a same-cycle handshake: head issued, the rest dropped.
        d_ready = 1'b0;
        push_one(32'h400, 32'h0020_8233, 3'd0, 1'b0);
        push_one(32'h404, 32'h0031_2023, 3'd3, 1'b0);
        @(negedge clk);
        chk("preflush_occupancy", 32'(occupancy), 32'd2);
        cyc();
        flush = 1'b1; d_ready = 1'b1;
        @(negedge clk);
        chk("flush_d_valid", 32'(d_valid), 32'd1);
        chk("flush_f_ready", 32'(f_ready), 32'd0);
        cyc();
        flush = 1'b0; d_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("postflush_occupancy", 32'(occupancy), 32'd0);
        chk("postflush_d_valid", 32'(d_valid), 32'd0);
        chk("postflush_f_ready", 32'(f_ready), 32'd1);
        cyc();

        // Illegal opcode issues as class 0, followed by jump/upper/branch classes.
        d_ready = 1'b1;
        push_one(32'h500, 32'h0000_007f, 3'd0, 1'b1);
        push_one(32'h504, 32'h0000_006f, 3'd5, 1'b0);
        push_one(32'h508, 32'h0000_1037, 3'd6, 1'b0);
        push_one(32'h50c, 32'h0000_0063, 3'd4, 1'b0);
        wait_empty();

        // Reset mid-DRAIN overrides a handshake in the same cycle.
        d_ready = 1'b0; ex_busy = 1'b1;
        push_one(32'h600, 32'h0000_0073, 3'd7, 1'b0);
        push_one(32'h604, 32'h0010_0093, 3'd1, 1'b0);
        @(negedge clk);
        chk("prerst_d_valid", 32'(d_valid), 32'd0);
        chk("prerst_occupancy", 32'(occupancy), 32'd2);
        cyc();
        rst = 1'b1; d_ready = 1'b1; ex_busy = 1'b0;
        cyc();
        rst = 1'b0; d_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_occupancy", 32'(occupancy), 32'd0);
        chk("midrst_d_valid", 32'(d_valid), 32'd0);
        chk("midrst_f_ready", 32'(f_ready), 32'd1);
        chk("midrst_d_instr", d_instr, 32'd0);
        cyc();

        // Back in RUN: a normal instruction issues.
        d_ready = 1'b1;
        push_one(32'h700, 32'h0070_0393, 3'd1, 1'b0);
        wait_empty();

        chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
        chk("issued_count", 32'(issued), 32'd12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_issue_controller.md
INSTR_ISSUE_CONTROLLER -- requirements
Module: instr_issue_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 2, queue entries; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port f_valid  input  1  fetch offers an instruction.
REQ-005 SHALL have port f_ready  output  1  queue accepts the offered instruction.
REQ-006 SHALL have port f_instr  input  32  fetched instruction word.
REQ-007 SHALL have port f_pc  input  32  PC of f_instr.
REQ-008 SHALL have port d_valid  output  1  head instruction offered to decode/execute.
REQ-009 SHALL have port d_ready  input  1  decode/execute accepts the head.
REQ-010 SHALL have port d_instr  output  32  head instruction word.
REQ-011 SHALL have port d_pc  output  32  head PC.
REQ-012 SHALL have port d_class  output  3  head class code (REQ-021).
REQ-013 SHALL have port d_illegal  output  1  head opcode is not a legal RV32I opcode.
REQ-014 SHALL have port ex_busy  input  1  execute still holds in-flight instructions.
REQ-015 SHALL have port flush  input  1  discard all queued instructions.
REQ-016 SHALL have port occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-017 SHALL store instructions in a DEPTH-entry circular FIFO (pc, instr) with wrapping read and write pointers.
REQ-018 SHALL drive f_ready = (occupancy < DEPTH) && !flush; a push occurs on f_valid && f_ready.
REQ-019 SHALL make a pushed entry visible at the head no earlier than the following cycle (no fetch-to-decode bypass; latency 1).
REQ-020 SHALL pop the head on d_valid && d_ready; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-021 SHALL classify head opcode instr[6:0]: 0110011->0 R, 0010011->1 OP-IMM, 0000011->2 LOAD, 0100011->3 STORE, 1100011->4 BRANCH, 1101111 or 1100111->5 JUMP, 0110111 or 0010111->6 UPPER, 1110011 or 0001111->7 SERIAL.
REQ-022 SHALL set d_illegal=1 and d_class=0 for any other opcode; illegal instructions issue like class 0.
REQ-023 SHALL implement states RUN, DRAIN, HOLD.
REQ-024 In RUN, d_valid SHALL be 1 iff occupancy>0 and the head is not class 7.
REQ-025 In RUN with non-empty queue and class-7 head, d_valid SHALL be 0 and the state SHALL go to DRAIN.
REQ-026 In DRAIN, d_valid SHALL equal !ex_busy; on handshake the state SHALL go to HOLD.
REQ-027 In HOLD, d_valid SHALL be 0 for at least one cycle; the state SHALL return to RUN on the first HOLD cycle after the entry cycle with ex_busy=0.
REQ-028 d_instr, d_pc, d_class, d_illegal SHALL reflect the head entry whenever occupancy>0, and SHALL be 0 when empty.
REQ-029 A flush SHALL set occupancy to 0, reset both pointers, and force state RUN in the next cycle, in any state.
REQ-030 flush with a handshake in the same cycle SHALL count as issued; remaining entries SHALL be dropped and no push SHALL occur.
REQ-031 The queue SHALL never overflow or underflow; pushes when full and pops when empty are impossible by construction.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL set occupancy=0, pointers=0, state RUN, and d_valid=0.
REQ-033 After reset, the block SHALL hold d_instr=d_pc=0, d_class=0, d_illegal=0, and f_ready=1.
REQ-034 Reset SHALL override flush and any handshake in the same cycle, including mid-DRAIN or mid-HOLD.
REQ-035 Queue storage contents need not be reset.

Verification
REQ-036 The bench SHALL cover: push 0x00500093 (addi) at pc 0x100, d_ready=1 -> next cycle d_valid=1, d_class=1, d_pc=0x100; popped, occupancy returns 0.
REQ-037 The bench SHALL cover: d_ready=0, push 3 instrs with DEPTH=2 -> f_ready=0 after 2 accepted; occupancy=2; third is held by fetch until a pop.
REQ-038 The bench SHALL cover: head 0x00000073 (ecall), ex_busy=1 for 4 cycles -> d_valid=0 for those cycles, then 1; after handshake, HOLD blocks the next instr until ex_busy=0.
REQ-039 The bench SHALL cover: occupancy=2, flush=1 with d_valid&&d_ready -> head counted issued, next cycle occupancy=0, d_valid=0, state RUN.
REQ-040 The bench SHALL cover: head opcode 0x7F -> d_illegal=1, d_class=0, issues normally.
REQ-041 The bench SHALL cover: rst=1 during DRAIN with occupancy=2 -> next cycle occupancy=0, d_valid=0, f_ready=1.
